// File: rtl/uarch_rst_seq.sv
// Staggered per-domain microarchitectural reset sequencer driven by the fence.t flush request.
// Latency: fixed PAD_CYCLES from start to done with UARCH_RST_PAD_EN; otherwise hold + NR_DOMAINS*STAGGER_CYCLES + 1.
// No backpressure: the request is edge-triggered, and falling edges seen outside IDLE are dropped.
module uarch_rst_seq #(
  parameter int NR_DOMAINS     = 4,
  parameter int HOLD_CYCLES    = 4,
  parameter int STAGGER_CYCLES = 2,
  parameter int PAD_CYCLES     = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rst_uarch_ni,
  input  logic [NR_DOMAINS-1:0] domain_mask_i,
  output logic [NR_DOMAINS-1:0] domain_rst_no,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pad_overrun_o,
  input  logic                  pad_overrun_clr_i
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int STG_W  = $clog2(STAGGER_CYCLES + 1);
  localparam int IDX_W  = $clog2(NR_DOMAINS + 1);

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NR_DOMAINS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ASSERT  = 3'd1,
    RELEASE = 3'd2,
    PAD     = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                  state_q, state_n;
  logic                    req_q;
  logic [NR_DOMAINS-1:0]   mask_q, mask_n;
  logic [HOLD_W-1:0]       hold_q, hold_n;
  logic [STG_W-1:0]        stg_q, stg_n;
  logic [IDX_W-1:0]        idx_q, idx_n;
  logic [NR_DOMAINS-1:0]   dom_q, dom_n;
  logic                    busy_q, busy_n;
  logic                    done_q;
  logic                    start;
  logic                    ovr_set;

  assign start = req_q & ~rst_uarch_ni;

`ifdef UARCH_RST_PAD_EN
  localparam int CYC_W = $clog2(PAD_CYCLES + 1) + 1;
  // cyc_q counts cycles since the start cycle; the DONE cycle lands on PAD_CYCLES-1.
  localparam logic [CYC_W-1:0] PAD_LAST = CYC_W'(PAD_CYCLES - 2);

  logic [CYC_W-1:0] cyc_q, cyc_n;
  logic             ovr_q;
`endif

  always_comb begin
    state_n = state_q;
    mask_n  = mask_q;
    hold_n  = hold_q;
    stg_n   = stg_q;
    idx_n   = idx_q;
    dom_n   = dom_q;
    ovr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        dom_n = '1;
        if (start) begin
          mask_n  = domain_mask_i;
          hold_n  = '0;
          dom_n   = ~domain_mask_i;
          state_n = ASSERT;
        end
      end
      ASSERT: begin
        dom_n = ~mask_q;
        if (!rst_uarch_ni) begin
          hold_n = '0;
        end else if (hold_q == HOLD_MAX) begin
          idx_n   = '0;
          stg_n   = '0;
          state_n = RELEASE;
        end else begin
          hold_n = hold_q + HOLD_W'(1);
        end
      end
      RELEASE: begin
        // Masked-off domains still burn their slot so timing never depends on the mask.
        if (stg_q == STG_LAST) begin
          stg_n = '0;
          idx_n = idx_q + IDX_W'(1);
          for (int i = 0; i < NR_DOMAINS; i++) begin
            if (idx_q == IDX_W'(i)) dom_n[i] = 1'b1;
          end
          if (idx_q == IDX_LAST) begin
`ifdef UARCH_RST_PAD_EN
            state_n = PAD;
`else
            state_n = DONE;
`endif
          end
        end else begin
          stg_n = stg_q + STG_W'(1);
        end
      end
`ifdef UARCH_RST_PAD_EN
      PAD: begin
        if (cyc_q >= PAD_LAST) begin
          state_n = DONE;
          ovr_set = (cyc_q > PAD_LAST);
        end
      end
`endif
      DONE: begin
        dom_n   = '1;
        state_n = IDLE;
      end
      default: begin
        dom_n   = '1;
        state_n = IDLE;
      end
    endcase
  end

  assign busy_n = (state_n == ASSERT) || (state_n == RELEASE) || (state_n == PAD);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      mask_q  <= '0;
      hold_q  <= '0;
      stg_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      req_q   <= rst_uarch_ni;
      mask_q  <= mask_n;
      hold_q  <= hold_n;
      stg_q   <= stg_n;
      idx_q   <= idx_n;
      dom_q   <= dom_n;
      busy_q  <= busy_n;
      done_q  <= (state_n == DONE);
    end
  end

`ifdef UARCH_RST_PAD_EN
  always_comb begin
    cyc_n = cyc_q;
    if (state_q == IDLE) begin
      if (start) cyc_n = CYC_W'(1);
    end else if (busy_q) begin
      if (cyc_q != '1) cyc_n = cyc_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      cyc_q <= cyc_n;
      // Set beats clear so a late overrun is never lost.
      if (ovr_set)                ovr_q <= 1'b1;
      else if (pad_overrun_clr_i) ovr_q <= 1'b0;
    end
  end

  assign pad_overrun_o = ovr_q;
`else
  logic unused_ovr;
  assign unused_ovr    = pad_overrun_clr_i | ovr_set;
  assign pad_overrun_o = 1'b0;
`endif

  assign domain_rst_no = dom_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
